// File: rtl/fibonacci.sv
// Iterative Fibonacci engine: start captures n, one addition per clock, done pulses with F(n).
// Optional FIB_SATURATE_EN: sticky overflow tracking, results past 2^32-1 read 32'hFFFF_FFFF.
module fibonacci #(
    parameter int unsigned N_WIDTH = 8
) (
    input  logic [N_WIDTH-1:0] num,
    input  logic               start,
    input  logic               clk,
    output logic [31:0]        fib,
    output logic               done,
    input  logic               rst
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   fib_q;
    logic [N_WIDTH-1:0]  cnt_q;
    logic                done_q;

`ifdef FIB_SATURATE_EN
    // Carry out of bit 31 marks the new b as no longer exact.
    logic [DATA_W:0]     sum_d;
    logic                ovf_a_q;
    logic                ovf_b_q;
    assign sum_d = {1'b0, a_q} + {1'b0, b_q};
`else
    logic [DATA_W-1:0]   sum_d;
    assign sum_d = a_q + b_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= DATA_W'(1);
            cnt_q   <= '0;
            fib_q   <= '0;
            done_q  <= 1'b0;
`ifdef FIB_SATURATE_EN
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
`endif
        end else if (start) begin
            // Start wins in any state; an aborted job never reports done.
            state_q <= RUN;
            a_q     <= '0;
            b_q     <= DATA_W'(1);
            cnt_q   <= num;
            done_q  <= 1'b0;
`ifdef FIB_SATURATE_EN
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        a_q   <= b_q;
                        b_q   <= sum_d[DATA_W-1:0];
                        cnt_q <= cnt_q - N_WIDTH'(1);
`ifdef FIB_SATURATE_EN
                        ovf_a_q <= ovf_b_q;
                        ovf_b_q <= ovf_a_q | ovf_b_q | sum_d[DATA_W];
`endif
                    end else begin
`ifdef FIB_SATURATE_EN
                        fib_q <= ovf_a_q ? {DATA_W{1'b1}} : a_q;
`else
                        fib_q <= a_q;
`endif
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fib  = fib_q;
    assign done = done_q;

endmodule

// File: tb/tb_fibonacci.sv
// Self-checking bench for fibonacci: randomized jobs against a Fibonacci table model.
module tb_fibonacci;

    localparam int unsigned N_WIDTH = 8;

    logic [N_WIDTH-1:0] num;
    logic               start;
    logic               clk;
    logic [31:0]        fib;
    logic               done;
    logic               rst;

    int tests = 0;
    int fails = 0;

    longint unsigned fib_tab [0:255];

    fibonacci #(.N_WIDTH(N_WIDTH)) dut (
        .num   (num),
        .start (start),
        .clk   (clk),
        .fib   (fib),
        .done  (done),
        .rst   (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact values up to F(93); beyond that the 64-bit wrap still keeps the low 32 bits right.
    function automatic logic [31:0] ref_fib(input int n);
        longint unsigned v;
        v = fib_tab[n];
`ifdef FIB_SATURATE_EN
        if (n >= 48) return 32'hFFFF_FFFF;
`endif
        return v[31:0];
    endfunction

    // Drives a one-edge start pulse; returns #1 after the start edge.
    task automatic start_job(input int n);
        start = 1'b1;
        num   = N_WIDTH'(n);
        @(posedge clk); #1;
        start = 1'b0;
        num   = N_WIDTH'($urandom);
    endtask

    // Counts edges from the last start edge until done; returns #1 after the done edge.
    task automatic wait_done(input int n, input logic [31:0] exp, input string tag);
        int k;
        k = 0;
        while (k < n + 10) begin
            @(posedge clk); #1;
            k++;
            if (done === 1'b1) break;
        end
        tests++;
        if (done !== 1'b1 || k != n + 1) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles (done=%b), expected %0d", tag, k, done, n + 1);
        end
        tests++;
        if (fib !== exp) begin
            fails++;
            $display("FAIL %s value: got %0d, expected %0d", tag, fib, exp);
        end
    endtask

    // One idle edge after done: pulse must end and fib must hold.
    task automatic check_pulse_end(input logic [31:0] exp, input string tag);
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || fib !== exp) begin
            fails++;
            $display("FAIL %s pulse_end: done=%b fib=%0d, expected done=0 fib=%0d", tag, done, fib, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (fib !== 32'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset: fib=%0d done=%b, expected fib=0 done=0", fib, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        start_job(0);
        wait_done(0, 32'd0, "n0");
        check_pulse_end(32'd0, "n0");
        start_job(1);
        wait_done(1, 32'd1, "n1");
        check_pulse_end(32'd1, "n1");
    endtask

    // n = 0..47 back-to-back: each new start is raised right after seeing done.
    task automatic test_back_to_back();
        int   bad;
        logic [31:0] prev;
        bad = 0;
        start_job(0);
        wait_done(0, ref_fib(0), "sweep0");
        for (int n = 1; n <= 47; n++) begin
            prev = fib;
            start_job(n);
            tests++;
            if (done !== 1'b0 || fib !== prev) begin
                fails++;
                $display("FAIL sweep pulse n=%0d: done=%b fib=%0d, expected done=0 fib=%0d", n, done, fib, prev);
            end
            wait_done(n, ref_fib(n), $sformatf("sweep%0d", n));
        end
        tests++;
        if (fib !== 32'd2971215073) begin
            fails++;
            $display("FAIL sweep F47: got %0d, expected 2971215073", fib);
        end
        check_pulse_end(32'd2971215073, "sweep47");
    endtask

    task automatic test_wrap();
        logic [31:0] exp48;
`ifdef FIB_SATURATE_EN
        exp48 = 32'hFFFF_FFFF;
`else
        exp48 = 32'd512559680;
`endif
        start_job(48);
        wait_done(48, exp48, "n48");
        check_pulse_end(exp48, "n48");
        start_job(255);
        wait_done(255, ref_fib(255), "n255");
        check_pulse_end(ref_fib(255), "n255");
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        start_job(40);
        repeat (4) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen++;
        end
        start_job(6);
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort early_done: got %0d pulses, expected 0", seen);
        end
        wait_done(6, 32'd8, "abort");
        check_pulse_end(32'd8, "abort");
    endtask

    task automatic test_reset_midrun();
        int seen;
        seen = 0;
        start_job(30);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (fib !== 32'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: fib=%0d done=%b, expected fib=0 done=0", fib, done);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0 || fib !== 32'd0) begin
            fails++;
            $display("FAIL midrun_quiet: pulses=%0d fib=%0d, expected 0 pulses fib=0", seen, fib);
        end
    endtask

    task automatic test_hold_start();
        int seen;
        seen = 0;
        start = 1'b1;
        num   = N_WIDTH'(5);
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen++;
        end
        start = 1'b0;
        num   = N_WIDTH'($urandom);
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL hold early_done: got %0d pulses, expected 0", seen);
        end
        wait_done(5, 32'd5, "hold");
        check_pulse_end(32'd5, "hold");
    endtask

    task automatic test_random();
        int n;
        int gap;
        for (int j = 0; j < 25; j++) begin
            n   = $urandom_range(0, 70);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                num = N_WIDTH'($urandom);
                @(posedge clk); #1;
            end
            start_job(n);
            wait_done(n, ref_fib(n), $sformatf("rand%0d_n%0d", j, n));
            check_pulse_end(ref_fib(n), $sformatf("rand%0d", j));
        end
    endtask

    initial begin
        fib_tab[0] = 64'd0;
        fib_tab[1] = 64'd1;
        for (int i = 2; i < 256; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];
        rst   = 1'b1;
        start = 1'b0;
        num   = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_abort();
        test_reset_midrun();
        test_hold_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fibonacci.md
# fibonacci

Sequential Fibonacci engine: on a start pulse it captures an index `n` and iteratively computes F(n) with F(0)=0, F(1)=1, one addition per clock. It drives a 32-bit result and a one-cycle `done` pulse when the result is valid. It is a self-contained arithmetic peripheral for a start/done handshake master; the controller issues the next request only after `done`.

## Interface
Parameters:
- `N_WIDTH`, default 8, width of the index input `num`.

Ports (declaration order `num, start, clk, fib, done, rst`, so positional instantiations with the first five ports remain valid):
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `num`  input  N_WIDTH  Fibonacci index n, unsigned; sampled only on a cycle where `start` is high.
- `start`  input  1  request strobe; level-sampled each rising edge.
- `fib`  output  32  result F(n); registered, holds until the next completion.
- `done`  output  1  registered one-cycle pulse: `fib` is valid for the last request.

## Operation
- Internal state: two 32-bit accumulators `a`, `b`; down-counter `cnt` (N_WIDTH bits); FSM {IDLE, RUN}.
- Reset (rst high at an edge, highest priority): FSM=IDLE, `fib`=0, `done`=0, `a`=0, `b`=1, `cnt`=0. Any computation in flight is discarded, with no `done`.
- `start` high at an edge (any state, rst low): `a`<=0, `b`<=1, `cnt`<=`num`, FSM<=RUN, `done`<=0. `start` during RUN aborts the current job and restarts with the new `num`; the aborted job produces no `done`.
- RUN with `cnt`!=0: `a`<=`b`, `b`<=`a`+`b` (mod 2^32), `cnt`<=`cnt`-1.
- RUN with `cnt`==0: `fib`<=`a`, `done`<=1, FSM<=IDLE.
- IDLE without start: `done`<=0; `fib` holds.
- Arithmetic is unsigned 32-bit and wraps modulo 2^32 by default. Results are exact for n<=47. F(47)=2971215073 is the largest exact value.
- `start` held high for several cycles restarts each cycle; `done` appears only after `start` falls.

## Timing
- `start` sampled at edge E; `done` is high for exactly the cycle following edge E+n+1. Latency is n+1 cycles, so n=0 gives `done` after E+1.
- `done` is never high for two consecutive cycles.
- `fib` updates at the same edge where `done` rises and is stable until the next completion.
- Back-to-back: a master that raises `start` for one cycle in response to `done` (asserted the edge after seeing `done`) gets the next `done` n'+2 cycles after the previous `done`. There is no stale second `done`.
- The `num` value is irrelevant except at the start edge.

## Configuration
- `FIB_SATURATE_EN` defined: each accumulator carries a sticky overflow bit, set when the addition feeding it carries out of bit 31 (the bit moves with the value from `b` to `a`). On completion, if `a`'s overflow bit is set, `fib`<=32'hFFFF_FFFF. Results for n<=47 are unchanged; n>=48 gives 4294967295. Overflow bits are cleared on start/reset.
- Not defined: plain modulo-2^32 wrap with no overflow tracking, e.g. F(48) reads 512559680.

## Test plan
- Reset, then `start` pulse with num=0 -> `done` one cycle after the edge E+1, `fib`=0; num=1 -> `fib`=1, `done` after E+2.
- Sweep n=0..47 with one-cycle start responses to `done` -> every `fib` matches the F(n) table (F(10)=55, F(20)=6765, F(47)=2971215073); each `done` exactly one cycle wide.
- num=48 -> `fib`=512559680 without `FIB_SATURATE_EN`; 4294967295 with it. num=255 also saturates with the macro defined.
- Start num=40, then after 5 cycles start num=6 -> single `done` 7 cycles after the second start, `fib`=8; no `done` for the n=40 job.
- rst asserted mid-RUN (num=30) -> next edge `fib`=0, `done`=0, no `done` afterwards until a new `start`.
- `start` held high 3 cycles with num=5 -> exactly one `done`, 6 cycles after the last start edge, `fib`=5.
